// File: rtl/pcileech_ft601_txbuf_pkg.sv
// pcileech_ft601_pkg: shared state encoding and word constants for the FT601
// transmit buffer and its helpers.
package pcileech_ft601_pkg;

  localparam int FT601_WORD_W = 32;

  // Word emitted to round a burst up to a multiple of four words.
  localparam logic [FT601_WORD_W-1:0] FILLER_WORD = 32'h66665555;

  typedef enum logic [1:0] {
    S_TXBUF_IDLE  = 2'd0,
    S_TXBUF_FILL  = 2'd1,
    S_TXBUF_DRAIN = 2'd2,
    S_TXBUF_PAD   = 2'd3
  } txbuf_state_e;

endpackage

// File: rtl/pcileech_ft601_txbuf_if.sv
// pcileech_ft601_txbuf_if: write side (from the TX mux) and read side (to the
// FT601 controller) of the transmit buffer.
// The master drives data and requests; the slave is the buffer itself.
interface pcileech_ft601_txbuf_if
  import pcileech_ft601_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
);

  logic [FT601_WORD_W-1:0] din;
  logic                    din_wr_en;
  logic                    full;
  logic                    overflow;
  logic                    dout_rd_en;
  logic [FT601_WORD_W-1:0] dout;
  logic                    dout_valid;
  logic                    dout_empty;
  logic [DEPTH_LOG2:0]     count;

  modport master (
    output din, din_wr_en, dout_rd_en,
    input  full, overflow, dout, dout_valid, dout_empty, count
  );

  modport slave (
    input  din, din_wr_en, dout_rd_en,
    output full, overflow, dout, dout_valid, dout_empty, count
  );

endinterface

// File: rtl/pcileech_ft601_txbuf_ram.sv
// pcileech_ft601_txbuf_ram: simple dual-port word store with a registered,
// enabled read port so it maps onto block RAM. The read register holds its
// value when no read is requested.
module pcileech_ft601_txbuf_ram
  import pcileech_ft601_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en_i,
  input  logic [DEPTH_LOG2-1:0]   wr_addr_i,
  input  logic [FT601_WORD_W-1:0] wr_data_i,
  input  logic                    rd_en_i,
  input  logic [DEPTH_LOG2-1:0]   rd_addr_i,
  output logic [FT601_WORD_W-1:0] rd_data_o
);

  logic [FT601_WORD_W-1:0] mem_q [2**DEPTH_LOG2];

  // Storage write port; the array itself carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port, cleared by reset so the visible word starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_o <= '0;
    end else if (rd_en_i) begin
      rd_data_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/pcileech_ft601_txbuf.sv
// pcileech_ft601_txbuf: burst-releasing transmit FIFO in front of the FT601
// controller. Words are held back until BURST_WORDS are queued or
// TIMEOUT_CYCLES pass with data pending, then drained to empty.
// Build option PCILEECH_FT601_TXBUF_PAD_EN: pad every burst to a multiple of
// four words with FILLER_WORD.
module pcileech_ft601_txbuf
  import pcileech_ft601_pkg::*;
#(
  parameter int DEPTH_LOG2     = 10,
  parameter int BURST_WORDS    = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                   clk,
  input logic                   rst,
  pcileech_ft601_txbuf_if.slave bus
);

  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PTR_W-1:0] BURST_THR = PTR_W'(BURST_WORDS);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT_CYCLES);

  txbuf_state_e            state_q, state_d;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q, count_w;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic                    overflow_q, dout_valid_q;
  logic                    full_w, dout_empty_w;
  logic                    wr_accept, rd_accept, ram_rd;
  logic [FT601_WORD_W-1:0] ram_rdata;
`ifdef PCILEECH_FT601_TXBUF_PAD_EN
  logic [1:0]              burst_cnt_q, burst_cnt_d;
  logic                    pad_sel_q;
`endif

  // Occupancy comes straight from the extra-MSB pointers.
  assign count_w   = wr_ptr_q - rd_ptr_q;
  assign full_w    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
  assign wr_accept = bus.din_wr_en & ~full_w;
  assign rd_accept = bus.dout_rd_en & ~dout_empty_w;
  assign ram_rd    = rd_accept && (state_q == S_TXBUF_DRAIN);

  pcileech_ft601_txbuf_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (wr_accept),
    .wr_addr_i(wr_ptr_q[DEPTH_LOG2-1:0]),
    .wr_data_i(bus.din),
    .rd_en_i  (ram_rd),
    .rd_addr_i(rd_ptr_q[DEPTH_LOG2-1:0]),
    .rd_data_o(ram_rdata)
  );

  // Readability gate: only an open burst exposes data to the controller.
  always_comb begin
    dout_empty_w = 1'b1;
    case (state_q)
      S_TXBUF_DRAIN: dout_empty_w = (count_w == '0);
`ifdef PCILEECH_FT601_TXBUF_PAD_EN
      S_TXBUF_PAD:   dout_empty_w = 1'b0;
`endif
      default:       dout_empty_w = 1'b1;
    endcase
  end

  // Burst FSM next state, release timer and (optionally) burst word counter.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
`ifdef PCILEECH_FT601_TXBUF_PAD_EN
    burst_cnt_d = burst_cnt_q;
`endif
    case (state_q)
      S_TXBUF_IDLE: begin
        if (wr_accept) state_d = S_TXBUF_FILL;
      end
      S_TXBUF_FILL: begin
        if ((count_w >= BURST_THR) || (timer_q == TMR_LAST)) begin
          state_d = S_TXBUF_DRAIN;
        end else begin
          timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;
        end
      end
      S_TXBUF_DRAIN: begin
`ifdef PCILEECH_FT601_TXBUF_PAD_EN
        if (rd_accept) burst_cnt_d = burst_cnt_q + 2'd1;
        if ((count_w == '0) && !wr_accept) begin
          state_d = (burst_cnt_q != 2'd0) ? S_TXBUF_PAD : S_TXBUF_IDLE;
        end
`else
        if ((count_w == '0) && !wr_accept) state_d = S_TXBUF_IDLE;
`endif
      end
`ifdef PCILEECH_FT601_TXBUF_PAD_EN
      S_TXBUF_PAD: begin
        if (rd_accept) begin
          burst_cnt_d = burst_cnt_q + 2'd1;
          if (burst_cnt_q == 2'd3) begin
            state_d = ((count_w != '0) || wr_accept) ? S_TXBUF_FILL : S_TXBUF_IDLE;
          end
        end
      end
`endif
      default: state_d = S_TXBUF_IDLE;
    endcase
  end

  // State, pointers, sticky overflow and read-valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_TXBUF_IDLE;
      timer_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      dout_valid_q <= 1'b0;
`ifdef PCILEECH_FT601_TXBUF_PAD_EN
      burst_cnt_q  <= 2'd0;
      pad_sel_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      dout_valid_q <= rd_accept;
      if (wr_accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (ram_rd)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (bus.din_wr_en && full_w) overflow_q <= 1'b1;
`ifdef PCILEECH_FT601_TXBUF_PAD_EN
      burst_cnt_q <= burst_cnt_d;
      if (rd_accept) pad_sel_q <= (state_q == S_TXBUF_PAD);
`endif
    end
  end

`ifdef PCILEECH_FT601_TXBUF_PAD_EN
  assign bus.dout = pad_sel_q ? FILLER_WORD : ram_rdata;
`else
  assign bus.dout = ram_rdata;
`endif
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_empty = dout_empty_w;
  assign bus.full       = full_w;
  assign bus.overflow   = overflow_q;
  assign bus.count      = count_w;

endmodule

// File: tb/tb_pcileech_ft601_txbuf.sv
// tb_pcileech_ft601_txbuf: directed bench for the FT601 transmit buffer.
// dut_a uses the default 1024-cycle timeout, dut_b a 16-cycle timeout; one
// shared stimulus/observation path is steered to either by 'sel'.
module tb_pcileech_ft601_txbuf;
  import pcileech_ft601_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic wr_v = 1'b0;
  logic rd_v = 1'b0;
  logic [31:0] din_v = '0;

  int checks = 0;
  int errors = 0;

  pcileech_ft601_txbuf_if #(.DEPTH_LOG2(10)) busA ();
  pcileech_ft601_txbuf_if #(.DEPTH_LOG2(10)) busB ();

  pcileech_ft601_txbuf #(
    .DEPTH_LOG2(10), .BURST_WORDS(256), .TIMEOUT_CYCLES(1024)
  ) dut_a (.clk(clk), .rst(rst), .bus(busA));

  pcileech_ft601_txbuf #(
    .DEPTH_LOG2(10), .BURST_WORDS(256), .TIMEOUT_CYCLES(16)
  ) dut_b (.clk(clk), .rst(rst), .bus(busB));

  always #5 clk = ~clk;

  assign busA.din        = din_v;
  assign busA.din_wr_en  = wr_v & ~sel;
  assign busA.dout_rd_en = rd_v & ~sel;
  assign busB.din        = din_v;
  assign busB.din_wr_en  = wr_v & sel;
  assign busB.dout_rd_en = rd_v & sel;

  logic [31:0] obs_dout;
  logic        obs_valid, obs_empty, obs_full, obs_ovf;
  logic [10:0] obs_count;
  txbuf_state_e obs_state;

  assign obs_dout  = sel ? busB.dout       : busA.dout;
  assign obs_valid = sel ? busB.dout_valid : busA.dout_valid;
  assign obs_empty = sel ? busB.dout_empty : busA.dout_empty;
  assign obs_full  = sel ? busB.full       : busA.full;
  assign obs_ovf   = sel ? busB.overflow   : busA.overflow;
  assign obs_count = sel ? busB.count      : busA.count;
  assign obs_state = sel ? dut_b.state_q   : dut_a.state_q;

  typedef struct {
    logic        wr;
    logic [31:0] din;
    logic        rd;
    logic [31:0] count;
    logic        empty;
    logic        valid;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] d, input logic rd);
    wr_v  = wr;
    din_v = d;
    rd_v  = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic setSel(input logic s);
    sel = s;
    #1;
  endtask

  task automatic doReset();
    wr_v = 1'b0;
    rd_v = 1'b0;
    rst  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] exp2[4];
    logic [31:0] got6[4];
    int nexp2;

    vecs[0] = '{wr:1'b0, din:32'h0,  rd:1'b1, count:32'd0, empty:1'b1, valid:1'b0};
    vecs[1] = '{wr:1'b1, din:32'h11, rd:1'b1, count:32'd1, empty:1'b1, valid:1'b0};
    vecs[2] = '{wr:1'b0, din:32'h0,  rd:1'b1, count:32'd1, empty:1'b1, valid:1'b0};
    vecs[3] = '{wr:1'b1, din:32'h22, rd:1'b0, count:32'd2, empty:1'b1, valid:1'b0};
    vecs[4] = '{wr:1'b1, din:32'h33, rd:1'b1, count:32'd3, empty:1'b1, valid:1'b0};
    vecs[5] = '{wr:1'b0, din:32'h0,  rd:1'b1, count:32'd3, empty:1'b1, valid:1'b0};

    // Reset values on both instances.
    doReset();
    for (int s = 0; s < 2; s++) begin
      setSel(s[0]);
      checkOutput("rst dout",     obs_dout, 32'h0);
      checkOutput("rst valid",    32'(obs_valid), 32'd0);
      checkOutput("rst empty",    32'(obs_empty), 32'd1);
      checkOutput("rst full",     32'(obs_full), 32'd0);
      checkOutput("rst overflow", 32'(obs_ovf), 32'd0);
      checkOutput("rst count",    32'(obs_count), 32'd0);
      checkOutput("rst state",    32'(obs_state), 32'(S_TXBUF_IDLE));
    end

    // Read requests while IDLE/FILL are ignored.
    $display("[TB] vector table: reads during IDLE/FILL");
    setSel(1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].din, vecs[i].rd);
      checkOutput($sformatf("vec%0d count", i), 32'(obs_count), vecs[i].count);
      checkOutput($sformatf("vec%0d empty", i), 32'(obs_empty), 32'(vecs[i].empty));
      checkOutput($sformatf("vec%0d valid", i), 32'(obs_valid), 32'(vecs[i].valid));
    end
    checkOutput("vec rd_ptr", 32'(dut_a.rd_ptr_q), 32'd0);
    checkOutput("vec state",  32'(obs_state), 32'(S_TXBUF_FILL));

    // Test 1: 256-word burst release, in-order drain.
    $display("[TB] test 1: full burst");
    doReset();
    setSel(1'b0);
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, i, 1'b1);
    checkOutput("t1 count256", 32'(obs_count), 32'd256);
    checkOutput("t1 empty before release", 32'(obs_empty), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t1 empty at release", 32'(obs_empty), 32'd0);
    n = 0;
    for (int c = 0; c < 300; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      if (obs_valid) begin
        checkOutput("t1 word", obs_dout, 32'(n));
        n++;
      end
    end
    checkOutput("t1 words out", 32'(n), 32'd256);
    checkOutput("t1 count end", 32'(obs_count), 32'd0);
    checkOutput("t1 empty end", 32'(obs_empty), 32'd1);
    checkOutput("t1 state end", 32'(obs_state), 32'(S_TXBUF_IDLE));

    // Test 2: timeout release of a short burst.
    $display("[TB] test 2: timeout release");
    doReset();
    setSel(1'b1);
    exp2[0] = 32'hA0; exp2[1] = 32'hA1; exp2[2] = 32'hA2; exp2[3] = FILLER_WORD;
`ifdef PCILEECH_FT601_TXBUF_PAD_EN
    nexp2 = 4;
`else
    nexp2 = 3;
`endif
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, exp2[i], 1'b1);
    for (int i = 0; i < 13; i++) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t2 held at cycle 15", 32'(obs_empty), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t2 released at cycle 16", 32'(obs_empty), 32'd0);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      if (obs_valid) begin
        if (n < 4) checkOutput("t2 word", obs_dout, exp2[n]);
        n++;
      end
    end
    checkOutput("t2 words out", 32'(n), 32'(nexp2));
    checkOutput("t2 empty end", 32'(obs_empty), 32'd1);
    checkOutput("t2 state end", 32'(obs_state), 32'(S_TXBUF_IDLE));

    // Test 4: simultaneous read and write with one word in DRAIN.
    $display("[TB] test 4: read+write at count 1");
    doReset();
    setSel(1'b1);
    applyStimulus(1'b1, 32'hB0, 1'b0);
    n = 0;
    while (obs_empty && n < 40) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      n++;
    end
    checkOutput("t4 release seen", 32'(obs_empty), 32'd0);
    checkOutput("t4 count1", 32'(obs_count), 32'd1);
    applyStimulus(1'b1, 32'hB1, 1'b1);
    checkOutput("t4 count same", 32'(obs_count), 32'd1);
    checkOutput("t4 state drain", 32'(obs_state), 32'(S_TXBUF_DRAIN));
    checkOutput("t4 empty", 32'(obs_empty), 32'd0);
    checkOutput("t4 valid0", 32'(obs_valid), 32'd1);
    checkOutput("t4 word0", obs_dout, 32'hB0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t4 valid1", 32'(obs_valid), 32'd1);
    checkOutput("t4 word1", obs_dout, 32'hB1);
    checkOutput("t4 count0", 32'(obs_count), 32'd0);

    // Test 3: fill to capacity, overflow, full drain.
    $display("[TB] test 3: fill and overflow");
    doReset();
    setSel(1'b0);
    for (int i = 0; i < 1024; i++) applyStimulus(1'b1, 32'h5A5A0000 | i, 1'b0);
    checkOutput("t3 full", 32'(obs_full), 32'd1);
    checkOutput("t3 count1024", 32'(obs_count), 32'd1024);
    checkOutput("t3 no overflow yet", 32'(obs_ovf), 32'd0);
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0);
    checkOutput("t3 overflow set", 32'(obs_ovf), 32'd1);
    checkOutput("t3 still full", 32'(obs_full), 32'd1);
    checkOutput("t3 count kept", 32'(obs_count), 32'd1024);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t3 overflow sticky", 32'(obs_ovf), 32'd1);
    n = 0;
    for (int c = 0; c < 1100; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      if (obs_valid) begin
        checkOutput("t3 word", obs_dout, 32'h5A5A0000 | 32'(n));
        n++;
      end
    end
    checkOutput("t3 words out", 32'(n), 32'd1024);
    checkOutput("t3 count end", 32'(obs_count), 32'd0);
    checkOutput("t3 full end", 32'(obs_full), 32'd0);
    checkOutput("t3 overflow end", 32'(obs_ovf), 32'd1);

    // Test 6: reset in the middle of a drain (overflow still set from test 3).
    $display("[TB] test 6: reset mid-drain");
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, 32'd1000 + i, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t6 released", 32'(obs_empty), 32'd0);
    n = 0;
    for (int c = 0; c < 200 && n < 100; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      if (obs_valid) n++;
    end
    checkOutput("t6 words before reset", 32'(n), 32'd100);
    checkOutput("t6 overflow before reset", 32'(obs_ovf), 32'd1);
    rst  = 1'b1;
    rd_v = 1'b0;
    #1;
    checkOutput("t6 count", 32'(obs_count), 32'd0);
    checkOutput("t6 empty", 32'(obs_empty), 32'd1);
    checkOutput("t6 valid", 32'(obs_valid), 32'd0);
    checkOutput("t6 overflow", 32'(obs_ovf), 32'd0);
    checkOutput("t6 dout", obs_dout, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t6 state idle", 32'(obs_state), 32'(S_TXBUF_IDLE));
    applyStimulus(1'b1, 32'hC0, 1'b0);
    applyStimulus(1'b1, 32'hC1, 1'b0);
    checkOutput("t6 new count", 32'(obs_count), 32'd2);
    n = 0;
    for (int c = 0; c < 1100 && n < 2; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      if (obs_valid) begin
        got6[n] = obs_dout;
        n++;
      end
    end
    checkOutput("t6 new words out", 32'(n), 32'd2);
    if (n >= 1) checkOutput("t6 new word0", got6[0], 32'hC0);
    if (n >= 2) checkOutput("t6 new word1", got6[1], 32'hC1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
